recirc_mux_sync_rx: RTL and testbench

//   Receive-domain half of a parametrised recirculation-mux synchroniser, clocked only by clk2.
//   The source domain presents a WIDTH-bit data_in bus and an EN qualifier.
//   EN is synchronised through SYNC_STAGES flops and edge-detected.
//   On each detected event, data_in is captured through a recirculation mux into a holding register.

---
 rtl/recirc_mux_sync_rx.sv | 141 ++++++++++++++
 tb/tb_recirc_mux_sync_rx.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/recirc_mux_sync_rx.sv
// -----------------------------------------------------------------------------
// recirc_mux_sync_rx
//   Receive-domain half of a recirculation-mux synchroniser (clk2 domain only).
//   The EN qualifier is passed through a SYNC_STAGES flop chain and then
//   edge-detected. Each detected event loads data_in through a recirculation
//   mux into the holding register. data_in itself is never synchronised. The
//   source keeps data_in stable from its EN change until the capture edge, so
//   sampling it directly on the event cycle is safe. Captured words are offered
//   on a valid/ready handshake. The block also reports a sticky overrun flag
//   and keeps a wrapping count of accepted captures.
//
// Ports
//   clk2         in   receive-domain clock
//   rst_clk2     in   asynchronous active-high reset, released on clk2
//   EN           in   asynchronous transfer qualifier from the source domain
//   data_in      in   asynchronous data word [WIDTH-1:0]
//   data_ready   in   consumer accepts data_out while data_valid=1
//   overrun_clr  in   clears the sticky overrun flag
//   data_out     out  captured data word [WIDTH-1:0]
//   data_valid   out  data_out holds an unconsumed word
//   overrun      out  sticky: an event arrived while the holding register was full
//   xfer_count   out  accepted captures, wraps modulo 2^CNT_WIDTH
// -----------------------------------------------------------------------------
module recirc_mux_sync_rx #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int TOGGLE_MODE = 0,
  parameter int CNT_WIDTH   = 8
) (
  input  logic                 clk2,
  input  logic                 rst_clk2,
  input  logic                 EN,
  input  logic [WIDTH-1:0]     data_in,
  input  logic                 data_ready,
  input  logic                 overrun_clr,
  output logic [WIDTH-1:0]     data_out,
  output logic                 data_valid,
  output logic                 overrun,
  output logic [CNT_WIDTH-1:0] xfer_count
);

  localparam logic EMPTY = 1'b0;
  localparam logic FULL  = 1'b1;

  // EN synchroniser chain; stage 0 is the only flop that sees the async input.
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   en_s;
  logic                   en_d_q;
  logic                   ev_pulse;

  genvar gi;
  generate
    for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
      if (gi == 0) begin : g_first
        always_ff @(posedge clk2 or posedge rst_clk2) begin
          if (rst_clk2) sync_q[gi] <= 1'b0;
          else          sync_q[gi] <= EN;
        end
      end else begin : g_rest
        always_ff @(posedge clk2 or posedge rst_clk2) begin
          if (rst_clk2) sync_q[gi] <= 1'b0;
          else          sync_q[gi] <= sync_q[gi-1];
        end
      end
    end
  endgenerate

  assign en_s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk2 or posedge rst_clk2) begin
    if (rst_clk2) en_d_q <= 1'b0;
    else          en_d_q <= en_s;
  end

  // Edge detector. It yields a single-cycle event per qualifying EN transition.
  generate
    if (TOGGLE_MODE != 0) begin : g_toggle
      assign ev_pulse = en_s ^ en_d_q;
    end else begin : g_rise
      assign ev_pulse = en_s & ~en_d_q;
    end
  endgenerate

  // Holding register, handshake state, overrun flag and transfer counter.
  logic                 state_q, state_d;
  logic [WIDTH-1:0]     hold_q, hold_d;
  logic                 overrun_q, overrun_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    state_d   = state_q;
    hold_d    = hold_q;          // recirculate unless a capture is accepted
    cnt_d     = cnt_q;
    // Clear first so that a same-cycle overrun below overrides it.
    overrun_d = overrun_q & ~overrun_clr;
    case (state_q)
      EMPTY: begin
        if (ev_pulse) begin
          state_d = FULL;
          hold_d  = data_in;
          cnt_d   = cnt_q + CNT_WIDTH'(1);
        end
      end
      FULL: begin
        if (ev_pulse) begin
          if (data_ready) begin
            // Old word consumed this cycle, so the new one takes its slot.
            hold_d = data_in;
            cnt_d  = cnt_q + CNT_WIDTH'(1);
          end else begin
            // The register is still occupied, so the new word is dropped.
            overrun_d = 1'b1;
          end
        end else if (data_ready) begin
          state_d = EMPTY;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk2 or posedge rst_clk2) begin
    if (rst_clk2) begin
      state_q   <= EMPTY;
      hold_q    <= '0;
      overrun_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      hold_q    <= hold_d;
      overrun_q <= overrun_d;
      cnt_q     <= cnt_d;
    end
  end

  assign data_out   = hold_q;
  assign data_valid = (state_q == FULL);
  assign overrun    = overrun_q;
  assign xfer_count = cnt_q;

endmodule

// File: tb/tb_recirc_mux_sync_rx.sv
module tb_recirc_mux_sync_rx;

  logic clk2;
  initial clk2 = 1'b0;
  always #7 clk2 = ~clk2;

  int n_checks;
  int n_pass;

  // ---------------- default instance ----------------
  logic       rst_def, d_en, d_ready, d_clr;
  logic [7:0] d_in, d_out;
  logic       d_valid, d_ovr;
  logic [7:0] d_cnt;

  recirc_mux_sync_rx u_def (
    .clk2(clk2), .rst_clk2(rst_def), .EN(d_en), .data_in(d_in),
    .data_ready(d_ready), .overrun_clr(d_clr), .data_out(d_out),
    .data_valid(d_valid), .overrun(d_ovr), .xfer_count(d_cnt)
  );

  // ---------------- TOGGLE_MODE=1, SYNC_STAGES=3 ----------------
  logic       rst_tog, t_en, t_ready, t_clr;
  logic [7:0] t_in, t_out;
  logic       t_valid, t_ovr;
  logic [7:0] t_cnt;

  recirc_mux_sync_rx #(.SYNC_STAGES(3), .TOGGLE_MODE(1)) u_tog (
    .clk2(clk2), .rst_clk2(rst_tog), .EN(t_en), .data_in(t_in),
    .data_ready(t_ready), .overrun_clr(t_clr), .data_out(t_out),
    .data_valid(t_valid), .overrun(t_ovr), .xfer_count(t_cnt)
  );

  // ---------------- CNT_WIDTH=2 ----------------
  logic       rst_cnt, c_en, c_ready, c_clr;
  logic [7:0] c_in, c_out;
  logic       c_valid, c_ovr;
  logic [1:0] c_cnt;

  recirc_mux_sync_rx #(.CNT_WIDTH(2)) u_cnt (
    .clk2(clk2), .rst_clk2(rst_cnt), .EN(c_en), .data_in(c_in),
    .data_ready(c_ready), .overrun_clr(c_clr), .data_out(c_out),
    .data_valid(c_valid), .overrun(c_ovr), .xfer_count(c_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
      $display("check %-14s obs=%0h exp=%0h ok", tag, obs, exp);
    end else begin
      $display("FAIL %-14s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // Advance n rising edges, then sit 1 ns past the last edge.
  task automatic step(input int n);
    repeat (n) @(posedge clk2);
    #1;
  endtask

  logic [1:0] wrap_exp [5];

  initial begin
    n_checks = 0;
    n_pass   = 0;
    wrap_exp[0] = 2'd1; wrap_exp[1] = 2'd2; wrap_exp[2] = 2'd3;
    wrap_exp[3] = 2'd0; wrap_exp[4] = 2'd1;

    rst_def = 1'b1; d_en = 1'b1; d_in = 8'hFF; d_ready = 1'b0; d_clr = 1'b0;
    rst_tog = 1'b1; t_en = 1'b0; t_in = 8'h00; t_ready = 1'b1; t_clr = 1'b0;
    rst_cnt = 1'b1; c_en = 1'b0; c_in = 8'h00; c_ready = 1'b1; c_clr = 1'b0;

    // 1. Reset with EN high and data all ones
    #20;
    check("rst_data", 32'(d_out), 32'h00);
    check("rst_valid", 32'(d_valid), 32'h0);
    check("rst_ovr", 32'(d_ovr), 32'h0);
    check("rst_cnt", 32'(d_cnt), 32'h00);
    d_en = 1'b0;
    step(1);
    rst_def = 1'b0; rst_tog = 1'b0; rst_cnt = 1'b0;
    step(3);
    check("post_rst_valid", 32'(d_valid), 32'h0);

    // 2. Single transfer with two-edge latency
    d_in = 8'hA5; d_en = 1'b1;
    step(2);
    check("lat_early", 32'(d_valid), 32'h0);
    step(1);
    check("single_valid", 32'(d_valid), 32'h1);
    check("single_data", 32'(d_out), 32'hA5);
    check("single_cnt", 32'(d_cnt), 32'h01);
    d_in = 8'h00;
    step(2);
    check("data_stable", 32'(d_out), 32'hA5);

    // 3. Level hold: a long high EN gives exactly one capture
    step(20);
    check("level_cnt", 32'(d_cnt), 32'h01);
    check("level_data", 32'(d_out), 32'hA5);
    d_en = 1'b0;
    step(4);
    d_in = 8'h3C; d_en = 1'b1; d_ready = 1'b1;
    step(3);
    check("second_data", 32'(d_out), 32'h3C);
    check("second_cnt", 32'(d_cnt), 32'h02);
    check("second_valid", 32'(d_valid), 32'h1);
    step(1);
    check("consumed", 32'(d_valid), 32'h0);
    check("empty_retain", 32'(d_out), 32'h3C);
    d_ready = 1'b0;

    // 4. Overrun
    d_en = 1'b0;
    step(4);
    d_in = 8'h11; d_en = 1'b1;
    step(3);
    check("fill_data", 32'(d_out), 32'h11);
    check("fill_cnt", 32'(d_cnt), 32'h03);
    d_en = 1'b0;
    step(4);
    d_in = 8'h22; d_en = 1'b1;
    step(3);
    check("ovr_data", 32'(d_out), 32'h11);
    check("ovr_flag", 32'(d_ovr), 32'h1);
    check("ovr_cnt", 32'(d_cnt), 32'h03);
    check("ovr_valid", 32'(d_valid), 32'h1);
    step(3);
    check("ovr_sticky", 32'(d_ovr), 32'h1);
    d_clr = 1'b1;
    step(1);
    d_clr = 1'b0;
    check("ovr_clr", 32'(d_ovr), 32'h0);
    d_en = 1'b0;
    step(4);
    d_in = 8'h33; d_en = 1'b1;
    step(2);
    d_clr = 1'b1;           // clear lands on the same edge as the new overrun
    step(1);
    d_clr = 1'b0;
    check("set_wins", 32'(d_ovr), 32'h1);
    check("set_wins_data", 32'(d_out), 32'h11);
    d_ready = 1'b1;
    step(1);
    check("drain", 32'(d_valid), 32'h0);

    // 5. TOGGLE_MODE=1, SYNC_STAGES=3
    t_in = 8'h01; t_en = 1'b1;
    step(3);
    check("tog_lat_early", 32'(t_valid), 32'h0);
    step(1);
    check("tog1_data", 32'(t_out), 32'h01);
    check("tog1_valid", 32'(t_valid), 32'h1);
    step(3);
    t_in = 8'h02; t_en = 1'b0;
    step(3);
    check("tog2_early", 32'(t_valid), 32'h0);
    step(1);
    check("tog2_data", 32'(t_out), 32'h02);
    check("tog2_valid", 32'(t_valid), 32'h1);
    step(3);
    t_in = 8'h03; t_en = 1'b1;
    step(4);
    check("tog3_data", 32'(t_out), 32'h03);
    check("tog_cnt", 32'(t_cnt), 32'h03);

    // 6a. Counter wrap with CNT_WIDTH=2
    for (int i = 0; i < 5; i++) begin
      c_in = 8'(8'h40 + i); c_en = 1'b1;
      step(4);
      check("wrap_cnt", 32'(c_cnt), 32'(wrap_exp[i]));
      c_en = 1'b0;
      step(4);
    end
    check("wrap_last_data", 32'(c_out), 32'h44);

    // 6b. Reset between EN change and capture discards the event
    d_ready = 1'b0;
    d_en = 1'b0;
    step(4);
    d_in = 8'h55; d_en = 1'b1;
    step(1);
    rst_def = 1'b1;
    #3;
    check("midrst_valid", 32'(d_valid), 32'h0);
    check("midrst_cnt", 32'(d_cnt), 32'h00);
    d_en = 1'b0;
    step(2);
    rst_def = 1'b0;
    step(4);
    check("midrst_data", 32'(d_out), 32'h00);
    check("midrst_valid2", 32'(d_valid), 32'h0);
    check("midrst_ovr", 32'(d_ovr), 32'h0);
    check("midrst_cnt2", 32'(d_cnt), 32'h00);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
